soc_rst_seq_ctrl: RTL and testbench

//  Programmable reset sequencer and end-of-test monitor for rv32ima SoC simulation and FPGA bring-up.
//  - Holds the harts in reset, then releases them one at a time.
//  - Can re-assert reset mid-run a set number of times.
//  - Snoops the data bus for tohost writes and reports pass, fail or watchdog timeout.
//  - Sits between the bench/board reset and the SoC top; replaces fixed delay-based reset pulsing.

---
 rtl/soc_rst_seq_ctrl_pkg.sv | 19 +
 rtl/soc_rst_stagger.sv | 39 +++
 rtl/soc_rst_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_soc_rst_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_rst_seq_ctrl_pkg.sv
// Shared definitions for the SoC reset sequencer: state encodings,
// the tohost pass code and a counter-width helper.
package soc_rst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    SEQ_HOLD     = 3'd0,
    SEQ_RELEASE  = 3'd1,
    SEQ_RUN      = 3'd2,
    SEQ_REASSERT = 3'd3,
    SEQ_DONE     = 3'd4
  } seq_state_e;

  localparam int unsigned TOHOST_PASS = 1;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/soc_rst_stagger.sv
// Per-hart staggered release mask: hart h is released h*STAGGER cycles
// after release_start rises; all_released flags the last hart's cycle.
module soc_rst_stagger
  import soc_rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned STAGGER   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 release_start,
  output logic [NUM_HARTS-1:0] mask,
  output logic                 all_released
);

  localparam int unsigned LAST = (NUM_HARTS - 1) * STAGGER;
  localparam int unsigned CW   = cnt_w(LAST);

  logic [CW-1:0] rel_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !release_start) begin
      rel_cnt <= '0;
    end else if (rel_cnt != CW'(LAST)) begin
      rel_cnt <= rel_cnt + 1'b1;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_mask
    if (h == 0) begin : g_first
      assign mask[h] = release_start;
    end else begin : g_rest
      assign mask[h] = release_start && (rel_cnt >= CW'(h * STAGGER));
    end
  end

  assign all_released = release_start && (rel_cnt == CW'(LAST));

endmodule

// File: rtl/soc_rst_seq_ctrl.sv
// Programmable reset sequencer and tohost end-of-test monitor.
//   state    | meaning
//   HOLD     | all harts in reset for HOLD_CYCLES
//   RELEASE  | harts released one by one, STAGGER apart
//   RUN      | harts running, tohost snooped, run/watchdog counting
//   REASSERT | one-cycle mid-run reset, then back to HOLD
//   DONE     | test finished, harts halted, flags sticky until rst_i
module soc_rst_seq_ctrl
  import soc_rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_HARTS   = 1,
  parameter int unsigned       HOLD_CYCLES = 10,
  parameter int unsigned       STAGGER     = 2,
  parameter int unsigned       RUN_CYCLES  = 48,
  parameter int unsigned       NUM_RESETS  = 1,
  parameter int unsigned       WDOG_CYCLES = 1024,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bus_valid_i,
  input  logic                 bus_we_i,
  input  logic [ADDR_W-1:0]    bus_addr_i,
  input  logic [DATA_W-1:0]    bus_wdata_i,
  output logic [NUM_HARTS-1:0] core_rst_o,
  output logic [2:0]           phase_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [DATA_W-2:0]    fail_code_o,
  output logic                 timeout_o,
  output logic [31:0]          cycle_cnt_o
);

  localparam int unsigned RL_W = cnt_w(NUM_RESETS);

  seq_state_e             state;
  logic [31:0]            hold_cnt;
  logic [31:0]            run_cnt;
  logic [RL_W-1:0]        resets_left;
  logic [NUM_HARTS-1:0]   rel_mask;
  logic                   all_released;
  logic                   tohost_wr;

  assign tohost_wr = bus_valid_i && bus_we_i && (bus_addr_i == TOHOST_ADDR)
                     && (bus_wdata_i != '0);
  assign phase_o   = state;

  soc_rst_stagger #(
    .NUM_HARTS(NUM_HARTS),
    .STAGGER  (STAGGER)
  ) u_stagger (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .release_start(state == SEQ_RELEASE),
    .mask         (rel_mask),
    .all_released (all_released)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= SEQ_HOLD;
      core_rst_o  <= '1;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_code_o <= '0;
      timeout_o   <= 1'b0;
      cycle_cnt_o <= '0;
      hold_cnt    <= '0;
      run_cnt     <= '0;
      resets_left <= RL_W'(NUM_RESETS);
    end else begin
      if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 1'b1;
      case (state)
        SEQ_HOLD: begin
          core_rst_o <= '1;
          if (hold_cnt == 32'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            state    <= SEQ_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SEQ_RELEASE: begin
          core_rst_o <= ~rel_mask;
          if (all_released) state <= SEQ_RUN;
        end
        SEQ_RUN: begin
          core_rst_o <= '0;
          // A tohost write beats any counter expiry in the same cycle.
          if (tohost_wr) begin
            done_o <= 1'b1;
            if (bus_wdata_i == DATA_W'(TOHOST_PASS)) begin
              pass_o <= 1'b1;
            end else if (bus_wdata_i[0]) begin
              fail_o      <= 1'b1;
              fail_code_o <= bus_wdata_i[DATA_W-1:1];
            end
            state <= SEQ_DONE;
          end else if (resets_left != '0 && run_cnt == 32'(RUN_CYCLES - 1)) begin
            resets_left <= resets_left - 1'b1;
            state       <= SEQ_REASSERT;
          end else if (resets_left == '0 && run_cnt == 32'(WDOG_CYCLES - 1)) begin
            timeout_o <= 1'b1;
            done_o    <= 1'b1;
            state     <= SEQ_DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        SEQ_REASSERT: begin
          core_rst_o <= '1;
          run_cnt    <= '0;
          state      <= SEQ_HOLD;
        end
        SEQ_DONE: begin
          core_rst_o <= '1;
        end
        default: begin
          core_rst_o <= '1;
          state      <= SEQ_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_rst_seq_ctrl.sv
// Bench for soc_rst_seq_ctrl with four staggered harts: vector table,
// hand-written reset corner cases and random bus traffic against a timeline model.
module tb_soc_rst_seq_ctrl;
  import soc_rst_seq_ctrl_pkg::*;

  localparam int          N      = 4;
  localparam int          S      = 2;
  localparam int          H      = 10;
  localparam int          RUN_C  = 48;
  localparam int          NRES   = 1;
  localparam int          WDOG   = 1024;
  localparam logic [31:0] TOHOST = 32'h8000_1000;
  localparam int          RUN_START = H + (N - 1) * S + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          bus_valid_i = 1'b0;
  logic          bus_we_i = 1'b0;
  logic [31:0]   bus_addr_i = '0;
  logic [31:0]   bus_wdata_i = '0;
  logic [N-1:0]  core_rst_o;
  logic [2:0]    phase_o;
  logic          done_o, pass_o, fail_o, timeout_o;
  logic [30:0]   fail_code_o;
  logic [31:0]   cycle_cnt_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_i = ~clk_i;

  soc_rst_seq_ctrl #(
    .NUM_HARTS(N), .HOLD_CYCLES(H), .STAGGER(S), .RUN_CYCLES(RUN_C),
    .NUM_RESETS(NRES), .WDOG_CYCLES(WDOG), .ADDR_W(32), .DATA_W(32),
    .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus_valid_i(bus_valid_i), .bus_we_i(bus_we_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .core_rst_o(core_rst_o),
    .phase_o(phase_o), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
    .fail_code_o(fail_code_o), .timeout_o(timeout_o), .cycle_cnt_o(cycle_cnt_o)
  );

  // Timeline model: epoch counts cycles since the last HOLD entry.
  int           m_epoch, m_left;
  bit           m_fin, m_reas, m_done, m_pass, m_fail, m_to;
  logic [30:0]  m_code;
  logic [N-1:0] m_core;
  logic [31:0]  m_cyc;

  function automatic seq_state_e cur_phase();
    if (m_fin)                   return SEQ_DONE;
    if (m_reas)                  return SEQ_REASSERT;
    if (m_epoch < H)             return SEQ_HOLD;
    if (m_epoch < RUN_START)     return SEQ_RELEASE;
    return SEQ_RUN;
  endfunction

  task automatic model_step(input bit rst, input bit valid, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    seq_state_e ph;
    int r, limit;
    if (rst) begin
      m_epoch = 0; m_left = NRES; m_fin = 0; m_reas = 0;
      m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_code = '0;
      m_core = '1; m_cyc = '0;
      return;
    end
    if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
    ph = cur_phase();
    case (ph)
      SEQ_RELEASE: for (int h = 0; h < N; h++) m_core[h] = !((m_epoch - H) >= h * S);
      SEQ_RUN:     m_core = '0;
      default:     m_core = '1;
    endcase
    if (ph == SEQ_DONE) begin
    end else if (ph == SEQ_REASSERT) begin
      m_reas  = 0;
      m_epoch = 0;
    end else if (ph == SEQ_RUN) begin
      r     = m_epoch - RUN_START;
      limit = (m_left > 0) ? RUN_C : WDOG;
      if (valid && we && addr == TOHOST && wdata != 0) begin
        m_fin = 1; m_done = 1;
        if (wdata == 1) m_pass = 1;
        else if (wdata[0]) begin m_fail = 1; m_code = wdata[31:1]; end
      end else if (r == limit - 1) begin
        if (m_left > 0) begin m_left--; m_reas = 1; end
        else begin m_to = 1; m_done = 1; m_fin = 1; end
      end else begin
        m_epoch++;
      end
    end else begin
      m_epoch++;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit valid, input bit we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    rst_i = rst; bus_valid_i = valid; bus_we_i = we;
    bus_addr_i = addr; bus_wdata_i = wdata;
    @(posedge clk_i);
    model_step(rst, valid, we, addr, wdata);
    @(negedge clk_i);
    chk("model_phase",    64'(phase_o),     64'(cur_phase()));
    chk("model_core_rst", 64'(core_rst_o),  64'(m_core));
    chk("model_done",     64'(done_o),      64'(m_done));
    chk("model_pass",     64'(pass_o),      64'(m_pass));
    chk("model_fail",     64'(fail_o),      64'(m_fail));
    chk("model_code",     64'(fail_code_o), 64'(m_code));
    chk("model_timeout",  64'(timeout_o),   64'(m_to));
    chk("model_cycles",   64'(cycle_cnt_o), 64'(m_cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  typedef struct {
    int          wr_epoch;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          chk_t;
    bit          done, pass, fail, tmo;
    logic [30:0] code;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] stg[19];

  initial begin
    // First RUN: epochs 17..64, REASSERT at 65; second RUN from 83, watchdog at 1106.
    vecs[0] = '{20,   TOHOST,       32'h1,  25,   1, 1, 0, 0, 31'd0};
    vecs[1] = '{30,   TOHOST,       32'h2B, 35,   1, 0, 1, 0, 31'd21};
    vecs[2] = '{5,    TOHOST,       32'h1,  16,   0, 0, 0, 0, 31'd0};
    vecs[3] = '{40,   TOHOST,       32'h4,  44,   1, 0, 0, 0, 31'd0};
    vecs[4] = '{25,   TOHOST,       32'h0,  30,   0, 0, 0, 0, 31'd0};
    vecs[5] = '{12,   TOHOST,       32'h1,  20,   0, 0, 0, 0, 31'd0};
    vecs[6] = '{65,   TOHOST,       32'h1,  70,   0, 0, 0, 0, 31'd0};
    vecs[7] = '{20,   TOHOST + 4,   32'h1,  25,   0, 0, 0, 0, 31'd0};
    vecs[8] = '{1106, TOHOST,       32'h1,  1110, 1, 1, 0, 0, 31'd0};
    vecs[9] = '{-1,   TOHOST,       32'h1,  1110, 1, 0, 0, 1, 31'd0};

    stg = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
            4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0, 4'h0};

    foreach (vecs[v]) begin
      step(1, 0, 0, '0, '0);
      for (int t = 1; t <= vecs[v].chk_t; t++) begin
        if (t - 1 == vecs[v].wr_epoch) step(0, 1, 1, vecs[v].addr, vecs[v].wdata);
        else step(0, 0, 0, '0, '0);
      end
      chk($sformatf("vec%0d_done", v),    64'(done_o),      64'(vecs[v].done));
      chk($sformatf("vec%0d_pass", v),    64'(pass_o),      64'(vecs[v].pass));
      chk($sformatf("vec%0d_fail", v),    64'(fail_o),      64'(vecs[v].fail));
      chk($sformatf("vec%0d_timeout", v), 64'(timeout_o),   64'(vecs[v].tmo));
      chk($sformatf("vec%0d_code", v),    64'(fail_code_o), 64'(vecs[v].code));
      if (vecs[v].done) chk($sformatf("vec%0d_halted", v), 64'(core_rst_o), 64'hF);
    end

    // Reset while DONE (vector 9 left the DUT timed out).
    step(1, 0, 0, '0, '0);
    chk("rst_done_timeout", 64'(timeout_o),   64'd0);
    chk("rst_done_done",    64'(done_o),      64'd0);
    chk("rst_done_cycles",  64'(cycle_cnt_o), 64'd0);
    chk("rst_done_core",    64'(core_rst_o),  64'hF);

    // Staggered release pattern, then reset in the middle of RELEASE.
    for (int t = 1; t <= 18; t++) begin
      step(0, 0, 0, '0, '0);
      chk($sformatf("stagger_t%0d", t), 64'(core_rst_o), 64'(stg[t]));
    end
    step(1, 0, 0, '0, '0);
    idle(13);
    step(1, 0, 0, '0, '0);
    chk("rst_rel_phase", 64'(phase_o),     64'(SEQ_HOLD));
    chk("rst_rel_core",  64'(core_rst_o),  64'hF);
    chk("rst_rel_cyc",   64'(cycle_cnt_o), 64'd0);
    idle(30);
    chk("restart_run", 64'(phase_o), 64'(SEQ_RUN));

    // Random bus traffic with occasional resets.
    step(1, 0, 0, '0, '0);
    for (int i = 0; i < 4000; i++) begin
      bit          r, vld, we;
      logic [31:0] a, d;
      int          sel;
      r   = ($urandom_range(0, 199) == 0);
      vld = $urandom_range(0, 1);
      we  = $urandom_range(0, 1);
      a   = ($urandom_range(0, 15) == 0) ? TOHOST : 32'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = 32'h0;
      else if (sel == 6) d = 32'h1;
      else if (sel == 7) d = 32'($urandom) & 32'hFFFF_FFFE;
      else               d = 32'($urandom);
      step(r, vld, we, a, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
